// File: rtl/ws2812b_timing_pkg.sv
// Shared WS2812B line timing (in 50 MHz clk counts) and receiver line-state encoding.
// Used by both the LED driver and the loop-back receiver.
package ws2812b_timing_pkg;

  localparam int BIT_PERIOD_CLKS        = 62;
  localparam int CODE1_HIGH_CLKS        = 39;
  localparam int CODE0_HIGH_CLKS        = 19;
  localparam int HIGH_THRESHOLD_DEFAULT = 29;
  localparam int MIN_HIGH_DEFAULT       = 8;
  localparam int MAX_HIGH_DEFAULT       = 55;
  localparam int RESET_LOW_CLKS_DEFAULT = 2500;

  localparam int BITS_PER_PIXEL = 24;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    IDLE      = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } rx_state_t;

endpackage

// File: rtl/nrz_bit_decoder.sv
// Synchronizes the WS2812B line, measures high/low widths and classifies each
// pulse into a data bit, a malformed-pulse error, or a reset-low (latch) event.
module nrz_bit_decoder
  import ws2812b_timing_pkg::*;
#(
  parameter int HIGH_THRESHOLD = HIGH_THRESHOLD_DEFAULT,
  parameter int MIN_HIGH       = MIN_HIGH_DEFAULT,
  parameter int MAX_HIGH       = MAX_HIGH_DEFAULT,
  parameter int RESET_LOW_CLKS = RESET_LOW_CLKS_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic leds_line,
  output logic bit_valid,
  output logic bit_value,
  output logic pulse_err,
  output logic reset_seen
);

  localparam int LW = $clog2(RESET_LOW_CLKS + 1);

  localparam logic [5:0]    THRESH_C   = 6'(HIGH_THRESHOLD);
  localparam logic [5:0]    MIN_HIGH_C = 6'(MIN_HIGH);
  localparam logic [5:0]    MAX_HIGH_C = 6'(MAX_HIGH);
  localparam logic [5:0]    SAT_HIGH_C = 6'(MAX_HIGH + 1);
  localparam logic [LW-1:0] LOW_LAST_C = LW'(RESET_LOW_CLKS - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic            prev_r;
  logic            rise_s;
  logic            fall_s;
  rx_state_t       state_r;
  rx_state_t       state_s;
  logic [5:0]      high_cnt_r;
  logic [5:0]      high_cnt_s;
  logic [LW-1:0]   low_cnt_r;
  logic [LW-1:0]   low_cnt_s;
  logic            bit_valid_s;
  logic            bit_value_s;
  logic            pulse_err_s;
  logic            reset_seen_s;
  logic            bit_valid_r;
  logic            bit_value_r;
  logic            pulse_err_r;
  logic            reset_seen_r;

  assign rise_s = sync2_r & ~prev_r;
  assign fall_s = ~sync2_r & prev_r;

  // Two-flop synchronizer plus delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= leds_line;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Line-state next-state logic, width counters and pulse classification.
  always_comb begin
    state_s      = state_r;
    high_cnt_s   = high_cnt_r;
    low_cnt_s    = low_cnt_r;
    bit_valid_s  = 1'b0;
    bit_value_s  = 1'b0;
    pulse_err_s  = 1'b0;
    reset_seen_s = 1'b0;
    case (state_r)
      SYNC_WAIT: begin
        if (sync2_r) begin
          low_cnt_s = '0;
        end else if (low_cnt_r >= LOW_LAST_C) begin
          low_cnt_s = '0;
          state_s   = IDLE;
        end else begin
          low_cnt_s = low_cnt_r + LW'(1);
        end
      end
      IDLE: begin
        if (rise_s) begin
          high_cnt_s = 6'd1;
          state_s    = HIGH;
        end else begin
          high_cnt_s = 6'd0;
        end
      end
      HIGH: begin
        if (high_cnt_r > MAX_HIGH_C) begin
          pulse_err_s = 1'b1;
          high_cnt_s  = 6'd0;
          low_cnt_s   = '0;
          state_s     = SYNC_WAIT;
        end else if (fall_s) begin
          high_cnt_s = 6'd0;
          if (high_cnt_r < MIN_HIGH_C) begin
            pulse_err_s = 1'b1;
            low_cnt_s   = '0;
            state_s     = SYNC_WAIT;
          end else begin
            bit_valid_s = 1'b1;
            bit_value_s = (high_cnt_r >= THRESH_C);
            low_cnt_s   = LW'(1);
            state_s     = LOW;
          end
        end else if (high_cnt_r == SAT_HIGH_C) begin
          high_cnt_s = high_cnt_r;
        end else begin
          high_cnt_s = high_cnt_r + 6'd1;
        end
      end
      LOW: begin
        if (sync2_r) begin
          high_cnt_s = 6'd1;
          low_cnt_s  = '0;
          state_s    = HIGH;
        end else if (low_cnt_r >= LOW_LAST_C) begin
          reset_seen_s = 1'b1;
          low_cnt_s    = '0;
          state_s      = IDLE;
        end else begin
          low_cnt_s = low_cnt_r + LW'(1);
        end
      end
      default: begin
        high_cnt_s = 6'd0;
        low_cnt_s  = '0;
        state_s    = SYNC_WAIT;
      end
    endcase
  end

  // State, counters and registered classification strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= SYNC_WAIT;
      high_cnt_r   <= 6'd0;
      low_cnt_r    <= '0;
      bit_valid_r  <= 1'b0;
      bit_value_r  <= 1'b0;
      pulse_err_r  <= 1'b0;
      reset_seen_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      high_cnt_r   <= high_cnt_s;
      low_cnt_r    <= low_cnt_s;
      bit_valid_r  <= bit_valid_s;
      bit_value_r  <= bit_value_s;
      pulse_err_r  <= pulse_err_s;
      reset_seen_r <= reset_seen_s;
    end
  end

  assign bit_valid  = bit_valid_r;
  assign bit_value  = bit_value_r;
  assign pulse_err  = pulse_err_r;
  assign reset_seen = reset_seen_r;

endmodule

// File: rtl/ws2812b_receiver.sv
// WS2812B receiver: assembles decoded bits into GRB pixels, tracks pixel position
// within the frame and reports frame latch and decode errors.
module ws2812b_receiver
  import ws2812b_timing_pkg::*;
#(
  parameter int MAX_POS        = 16,
  parameter int HIGH_THRESHOLD = HIGH_THRESHOLD_DEFAULT,
  parameter int MIN_HIGH       = MIN_HIGH_DEFAULT,
  parameter int MAX_HIGH       = MAX_HIGH_DEFAULT,
  parameter int RESET_LOW_CLKS = RESET_LOW_CLKS_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         leds_line,
  output logic                         pixel_valid,
  output logic [$clog2(MAX_POS)-1:0]   pixel_index,
  output logic [7:0]                   pixel_green,
  output logic [7:0]                   pixel_red,
  output logic [7:0]                   pixel_blue,
  output logic                         frame_done,
  output logic [$clog2(MAX_POS):0]     pixel_count,
  output logic                         err_pulse
);

  localparam int IW = $clog2(MAX_POS);
  localparam int CW = IW + 1;

  localparam logic [CW-1:0] MAX_POS_C  = CW'(MAX_POS);
  localparam logic [4:0]    LAST_BIT_C = 5'(BITS_PER_PIXEL - 1);

  logic            bit_valid_s;
  logic            bit_value_s;
  logic            pulse_err_s;
  logic            reset_seen_s;
  logic [23:0]     word_s;
  logic [22:0]     shift_r;
  logic [4:0]      bit_cnt_r;
  logic [CW-1:0]   pix_cnt_r;
  logic            pixel_valid_r;
  logic [IW-1:0]   pixel_index_r;
  logic [7:0]      pixel_green_r;
  logic [7:0]      pixel_red_r;
  logic [7:0]      pixel_blue_r;
  logic            frame_done_r;
  logic [CW-1:0]   pixel_count_r;
  logic            err_pulse_r;

  nrz_bit_decoder #(
    .HIGH_THRESHOLD (HIGH_THRESHOLD),
    .MIN_HIGH       (MIN_HIGH),
    .MAX_HIGH       (MAX_HIGH),
    .RESET_LOW_CLKS (RESET_LOW_CLKS)
  ) u_decoder (
    .clk        (clk),
    .rst_n      (rst_n),
    .leds_line  (leds_line),
    .bit_valid  (bit_valid_s),
    .bit_value  (bit_value_s),
    .pulse_err  (pulse_err_s),
    .reset_seen (reset_seen_s)
  );

  // The 24th bit is taken straight from the decoder so the pixel is presented
  // one cycle after its last bit is classified.
  assign word_s = {shift_r, bit_value_s};

  // Pixel assembly, frame counters and registered output strobes/fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r       <= 23'd0;
      bit_cnt_r     <= 5'd0;
      pix_cnt_r     <= '0;
      pixel_valid_r <= 1'b0;
      pixel_index_r <= '0;
      pixel_green_r <= 8'd0;
      pixel_red_r   <= 8'd0;
      pixel_blue_r  <= 8'd0;
      frame_done_r  <= 1'b0;
      pixel_count_r <= '0;
      err_pulse_r   <= 1'b0;
    end else begin
      pixel_valid_r <= 1'b0;
      frame_done_r  <= 1'b0;
      err_pulse_r   <= 1'b0;
      if (pulse_err_s) begin
        // Malformed pulse abandons the frame; decoder resynchronizes on reset-low.
        err_pulse_r <= 1'b1;
        bit_cnt_r   <= 5'd0;
        pix_cnt_r   <= '0;
      end else if (bit_valid_s) begin
        shift_r <= word_s[22:0];
        if (bit_cnt_r == LAST_BIT_C) begin
          bit_cnt_r <= 5'd0;
          if (pix_cnt_r < MAX_POS_C) begin
            pixel_valid_r <= 1'b1;
            pixel_index_r <= pix_cnt_r[IW-1:0];
            pixel_green_r <= word_s[23:16];
            pixel_red_r   <= word_s[15:8];
            pixel_blue_r  <= word_s[7:0];
            pix_cnt_r     <= pix_cnt_r + CW'(1);
          end else begin
            err_pulse_r <= 1'b1;
          end
        end else begin
          bit_cnt_r <= bit_cnt_r + 5'd1;
        end
      end else if (reset_seen_s) begin
        frame_done_r  <= 1'b1;
        pixel_count_r <= pix_cnt_r;
        err_pulse_r   <= (bit_cnt_r != 5'd0);
        bit_cnt_r     <= 5'd0;
        pix_cnt_r     <= '0;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  assign pixel_valid = pixel_valid_r;
  assign pixel_index = pixel_index_r;
  assign pixel_green = pixel_green_r;
  assign pixel_red   = pixel_red_r;
  assign pixel_blue  = pixel_blue_r;
  assign frame_done  = frame_done_r;
  assign pixel_count = pixel_count_r;
  assign err_pulse   = err_pulse_r;

endmodule

// File: tb/tb_ws2812b_receiver.sv
// Directed self-checking bench for ws2812b_receiver: drives NRZ pulses with the
// driver timing and compares logged strobes against hand-computed values.
module tb_ws2812b_receiver;

  localparam int T1H  = 39;
  localparam int T0H  = 19;
  localparam int TBIT = 62;
  localparam int GAP  = 2520;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       leds_line = 1'b0;
  logic       pixel_valid;
  logic [3:0] pixel_index;
  logic [7:0] pixel_green;
  logic [7:0] pixel_red;
  logic [7:0] pixel_blue;
  logic       frame_done;
  logic [4:0] pixel_count;
  logic       err_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int last_rise = 0;

  int pv_tot = 0;
  int fd_tot = 0;
  int err_tot = 0;
  int overlap_tot = 0;
  int pv_cyc = 0;
  int fd_cyc = 0;
  int err_cyc = 0;
  int fd_pc = 0;
  int pv_base = 0;
  int fd_base = 0;
  int err_base = 0;
  int pv_idx [0:63];
  logic [23:0] pv_data [0:63];

  ws2812b_receiver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .leds_line   (leds_line),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .pixel_green (pixel_green),
    .pixel_red   (pixel_red),
    .pixel_blue  (pixel_blue),
    .frame_done  (frame_done),
    .pixel_count (pixel_count),
    .err_pulse   (err_pulse)
  );

  always #10 clk = ~clk;

  // Event logger, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (pixel_valid) begin
      if (pv_tot < 64) begin
        pv_idx[pv_tot]  = int'(pixel_index);
        pv_data[pv_tot] = {pixel_green, pixel_red, pixel_blue};
      end
      pv_tot = pv_tot + 1;
      pv_cyc = cyc;
    end
    if (frame_done) begin
      fd_tot = fd_tot + 1;
      fd_cyc = cyc;
      fd_pc  = int'(pixel_count);
    end
    if (err_pulse) begin
      err_tot = err_tot + 1;
      err_cyc = cyc;
    end
    if (err_pulse && pixel_valid) overlap_tot = overlap_tot + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    pv_base  = pv_tot;
    fd_base  = fd_tot;
    err_base = err_tot;
  endtask

  task automatic drive(input logic v, input int n);
    leds_line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pulse(input int hi, input int lo);
    last_rise = cyc;
    drive(1'b1, hi);
    last_fall = cyc;
    drive(1'b0, lo);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(T1H, TBIT - T1H);
    else   send_pulse(T0H, TBIT - T0H);
  endtask

  task automatic send_pixel(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctl"}, 32'({pixel_valid, pixel_index, frame_done, pixel_count, err_pulse}), 32'd0);
    check_eq({tag, "_pix"}, 32'({pixel_green, pixel_red, pixel_blue}), 32'd0);
  endtask

  initial begin
    logic [7:0]  b8;
    logic [19:0] tail;
    int          d;

    // Reset values
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    rst_n = 1'b1;
    drive(1'b0, GAP);

    // Single pixel with driver timing
    mark();
    send_pixel(24'hA53CF0);
    drive(1'b0, GAP);
    check_eq("one_pv_cnt", 32'(pv_tot - pv_base), 32'd1);
    check_eq("one_idx", 32'(pv_idx[pv_base]), 32'd0);
    check_eq("one_data", 32'(pv_data[pv_base]), 32'h00A53CF0);
    check_eq("one_pv_lat", 32'(pv_cyc - last_fall), 32'd4);
    check_eq("one_fd_cnt", 32'(fd_tot - fd_base), 32'd1);
    check_eq("one_fd_pc", 32'(fd_pc), 32'd1);
    check_eq("one_fd_lat", 32'(fd_cyc - last_fall), 32'd2503);
    check_eq("one_err", 32'(err_tot - err_base), 32'd0);

    // 17 pixels into a 16-position frame
    mark();
    for (int i = 0; i < 17; i++) begin
      b8 = 8'(i);
      send_pixel({b8, ~b8, b8 ^ 8'h55});
    end
    check_eq("ovf_err_lat", 32'(err_cyc - last_fall), 32'd4);
    drive(1'b0, GAP);
    check_eq("ovf_pv_cnt", 32'(pv_tot - pv_base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      b8 = 8'(i);
      check_eq("ovf_idx", 32'(pv_idx[pv_base + i]), 32'(i));
      check_eq("ovf_data", 32'(pv_data[pv_base + i]), 32'({b8, ~b8, b8 ^ 8'h55}));
    end
    check_eq("ovf_err_cnt", 32'(err_tot - err_base), 32'd1);
    check_eq("ovf_fd_cnt", 32'(fd_tot - fd_base), 32'd1);
    check_eq("ovf_fd_pc", 32'(fd_pc), 32'd16);

    // Over-long high pulse at bit 5, then resync and a clean pixel
    mark();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    last_rise = cyc;
    drive(1'b1, 60);
    drive(1'b0, GAP);
    check_eq("long_err_cnt", 32'(err_tot - err_base), 32'd1);
    d = err_cyc - last_rise;
    check_eq("long_err_time", 32'(d >= 56 && d <= 60), 32'd1);
    check_eq("long_pv_cnt", 32'(pv_tot - pv_base), 32'd0);
    check_eq("long_fd_cnt", 32'(fd_tot - fd_base), 32'd0);
    mark();
    send_pixel(24'h123456);
    drive(1'b0, GAP);
    check_eq("resync_pv_cnt", 32'(pv_tot - pv_base), 32'd1);
    check_eq("resync_idx", 32'(pv_idx[pv_base]), 32'd0);
    check_eq("resync_data", 32'(pv_data[pv_base]), 32'h00123456);
    check_eq("resync_fd_pc", 32'(fd_pc), 32'd1);

    // Partial pixel (12 bits) then reset-low
    mark();
    for (int i = 0; i < 12; i++) send_bit(i[0]);
    drive(1'b0, GAP);
    check_eq("part_fd_cnt", 32'(fd_tot - fd_base), 32'd1);
    check_eq("part_fd_pc", 32'(fd_pc), 32'd0);
    check_eq("part_err_cnt", 32'(err_tot - err_base), 32'd1);
    check_eq("part_err_with_fd", 32'(err_cyc), 32'(fd_cyc));

    // Boundary widths 28/29/8/55 then a driver-timed tail
    mark();
    tail = 20'hBCDEF;
    send_pulse(28, TBIT - 28);
    send_pulse(29, TBIT - 29);
    send_pulse(8, TBIT - 8);
    send_pulse(55, TBIT - 55);
    for (int i = 19; i >= 0; i--) send_bit(tail[i]);
    drive(1'b0, GAP);
    check_eq("bnd_pv_cnt", 32'(pv_tot - pv_base), 32'd1);
    check_eq("bnd_data", 32'(pv_data[pv_base]), 32'h005BCDEF);
    check_eq("bnd_err_cnt", 32'(err_tot - err_base), 32'd0);
    check_eq("bnd_fd_pc", 32'(fd_pc), 32'd1);

    // Width 7 is too short
    mark();
    send_pulse(7, TBIT - 7);
    drive(1'b0, GAP);
    check_eq("short_err_cnt", 32'(err_tot - err_base), 32'd1);
    check_eq("short_pv_cnt", 32'(pv_tot - pv_base), 32'd0);
    check_eq("short_fd_cnt", 32'(fd_tot - fd_base), 32'd0);

    // Asynchronous reset mid-pixel, then SYNC_WAIT must ignore a frame in progress
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    leds_line = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    mark();
    drive(1'b0, 100);
    send_pixel(24'h0F0F0F);
    drive(1'b0, GAP);
    check_eq("sync_pv_cnt", 32'(pv_tot - pv_base), 32'd0);
    check_eq("sync_fd_cnt", 32'(fd_tot - fd_base), 32'd0);
    check_eq("sync_err_cnt", 32'(err_tot - err_base), 32'd0);
    mark();
    send_pixel(24'hC30F96);
    drive(1'b0, GAP);
    check_eq("post_rst_pv_cnt", 32'(pv_tot - pv_base), 32'd1);
    check_eq("post_rst_idx", 32'(pv_idx[pv_base]), 32'd0);
    check_eq("post_rst_data", 32'(pv_data[pv_base]), 32'h00C30F96);
    check_eq("post_rst_fd_pc", 32'(fd_pc), 32'd1);

    check_eq("err_pv_overlap", 32'(overlap_tot), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
